// File: rtl/branch_pkg.sv
// Shared decode constants, FSM state type and immediate extraction for the
// branch controller slice.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } stateT;

  typedef enum logic [1:0] {
    IMM_B = 2'd0,
    IMM_J = 2'd1,
    IMM_I = 2'd2
  } immFmtT;

  function automatic logic [31:0] extractImm(input logic [31:0] instr, input immFmtT fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoder/comparator-facing bundle of the branch controller.
interface branch_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      instr_i;
  logic             instr_vld_i;
  logic             stall_i;
  logic [31:0]      rs1_data_i;
  logic             br_less_i;
  logic             br_equal_i;
  logic             clr_cnt_i;
  logic             br_un_o;
  logic             taken_o;
  logic [31:0]      pc_o;
  logic [31:0]      pc_four_o;
  logic             misalign_o;
  logic [31:0]      epc_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  modport master (
    output instr_i, instr_vld_i, stall_i, rs1_data_i, br_less_i, br_equal_i, clr_cnt_i,
    input  br_un_o, taken_o, pc_o, pc_four_o, misalign_o, epc_o, br_cnt_o, taken_cnt_o
  );

  modport slave (
    input  instr_i, instr_vld_i, stall_i, rs1_data_i, br_less_i, br_equal_i, clr_cnt_i,
    output br_un_o, taken_o, pc_o, pc_four_o, misalign_o, epc_o, br_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cntR;

  // Counter register: clear, saturating increment or hold
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cntR <= {CNT_W{1'b0}};
    end else if (clr) begin
      cntR <= {CNT_W{1'b0}};
    end else if (inc && (cntR != {CNT_W{1'b1}})) begin
      cntR <= cntR + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cntR <= cntR;
    end
  end

  assign cnt = cntR;

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and architectural PC owner: decodes control flow, resolves
// taken/not-taken, steers the PC and traps misaligned targets.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  branch_ctrl_if.slave bus
);

  stateT       stateR, stateS;
  logic [31:0] pcR, pcS, epcR, epcS;
  logic        misalignR, misalignS;
  logic [31:0] targetS, pcFourS;
  logic        isBranchS, isJalS, isJalrS, condTakenS, takenS, trapS, updateS;
  logic        brIncS, takenIncS;
  logic [6:0]  opcodeS;
  logic [2:0]  funct3S;

  assign opcodeS = bus.instr_i[6:0];
  assign funct3S = bus.instr_i[14:12];
  assign pcFourS = pcR + 32'd4;

  // Opcode decode and control-flow target generation
  always_comb begin
    isBranchS = 1'b0;
    isJalS    = 1'b0;
    isJalrS   = 1'b0;
    targetS   = pcFourS;
    case (opcodeS)
      OP_BRANCH: begin
        isBranchS = 1'b1;
        targetS   = pcR + extractImm(bus.instr_i, IMM_B);
      end
      OP_JAL: begin
        isJalS  = 1'b1;
        targetS = pcR + extractImm(bus.instr_i, IMM_J);
      end
      OP_JALR: begin
        isJalrS = 1'b1;
        targetS = (bus.rs1_data_i + extractImm(bus.instr_i, IMM_I)) & ~32'h0000_0001;
      end
      default: begin
        targetS = pcFourS;
      end
    endcase
  end

  // Conditional outcome from the comparator flags; funct3 010/011 never take
  always_comb begin
    condTakenS = 1'b0;
    case (funct3S)
      F3_BEQ:           condTakenS = bus.br_equal_i;
      F3_BNE:           condTakenS = ~bus.br_equal_i;
      F3_BLT, F3_BLTU:  condTakenS = bus.br_less_i;
      F3_BGE, F3_BGEU:  condTakenS = ~bus.br_less_i;
      default:          condTakenS = 1'b0;
    endcase
  end

  assign takenS  = bus.instr_vld_i & (isJalS | isJalrS | (isBranchS & condTakenS));
  assign trapS   = takenS & targetS[1];
  // No instruction retires during the trap cycle
  assign updateS = bus.instr_vld_i & ~bus.stall_i & (stateR == ST_RUN);

  // State and architectural registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateR    <= ST_RUN;
      pcR       <= RESET_PC;
      epcR      <= 32'h0000_0000;
      misalignR <= 1'b0;
    end else begin
      stateR    <= stateS;
      pcR       <= pcS;
      epcR      <= epcS;
      misalignR <= misalignS;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    stateS    = stateR;
    pcS       = pcR;
    epcS      = epcR;
    misalignS = 1'b0;
    case (stateR)
      ST_RUN: begin
        if (updateS) begin
          if (trapS) begin
            pcS       = TRAP_PC;
            epcS      = pcR;
            misalignS = 1'b1;
            stateS    = ST_TRAP;
          end else if (takenS) begin
            pcS = targetS;
          end else begin
            pcS = pcFourS;
          end
        end else begin
          pcS = pcR;
        end
      end
      ST_TRAP: begin
        stateS = ST_RUN;
      end
      default: begin
        stateS = ST_RUN;
      end
    endcase
  end

  assign brIncS    = updateS & isBranchS;
  assign takenIncS = brIncS & takenS;

  sat_counter #(.CNT_W(CNT_W)) uBrCnt (
    .clk  (clk_i),
    .rstN (rst_ni),
    .inc  (brIncS),
    .clr  (bus.clr_cnt_i),
    .cnt  (bus.br_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) uTakenCnt (
    .clk  (clk_i),
    .rstN (rst_ni),
    .inc  (takenIncS),
    .clr  (bus.clr_cnt_i),
    .cnt  (bus.taken_cnt_o)
  );

  assign bus.br_un_o    = isBranchS & bus.instr_i[13];
  assign bus.taken_o    = takenS;
  assign bus.pc_o       = pcR;
  assign bus.pc_four_o  = pcFourS;
  assign bus.misalign_o = misalignR;
  assign bus.epc_o      = epcR;

endmodule
